// File: rtl/lcd_static_drv_pkg.sv
// Shared constants for the static LCD driver: segment bit positions,
// hex-to-7-segment patterns and the backplane phase encodings.
package lcd_static_drv_pkg;

    localparam logic [0:0] PH_POS = 1'b0;
    localparam logic [0:0] PH_NEG = 1'b1;

    localparam int SEG_A  = 0;
    localparam int SEG_DP = 7;

    // Entries ordered F down to 0 so that SEG7_LUT[hex] selects digit hex; bits are {g,f,e,d,c,b,a}
    localparam logic [15:0][6:0] SEG7_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational hex digit to 7-segment pattern decoder, {g,f,e,d,c,b,a}, 1 = segment on.
module seg7_hex_dec
    import lcd_static_drv_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    logic [6:0] seg_s;

    // Table lookup of the segment pattern
    always_comb begin
        seg_s = SEG7_LUT[hex];
    end

    assign seg = seg_s;

endmodule

// File: rtl/lcd_static_drv.sv
// AC drive sequencer for a static 7-segment LCD: two-phase backplane, XORed segments,
// period-aligned value loading and a frame_tick loss watchdog that parks the glass at 0 V.
module lcd_static_drv
    import lcd_static_drv_pkg::*;
#(
    parameter int NDIG     = 4,
    parameter int LZB      = 1,
    parameter int TICK_TMO = 65535
) (
    input  logic                osc_clk,
    input  logic                nrst,
    input  logic                frame_tick,
    input  logic                load_req,
    input  logic [4*NDIG-1:0]   load_hex,
    input  logic [NDIG-1:0]     load_dp,
    input  logic                load_blank,
    output logic                load_ack,
    output logic                lcd_com,
    output logic [8*NDIG-1:0]   lcd_seg,
    output logic                tick_lost
);

    localparam int              CW       = $clog2(TICK_TMO + 1);
    localparam logic [CW-1:0]   TMO_C    = CW'(TICK_TMO);
    localparam logic [CW-1:0]   TMO_M1_C = CW'(TICK_TMO - 1);

    logic [0:0]         phase_r, phase_nxt_s;
    logic [CW-1:0]      tmo_cnt_r, tmo_cnt_nxt_s;
    logic               tick_lost_r, tick_lost_nxt_s;
    logic [4*NDIG-1:0]  sh_hex_r, sh_hex_nxt_s;
    logic [NDIG-1:0]    sh_dp_r, sh_dp_nxt_s;
    logic               sh_blank_r, sh_blank_nxt_s;
    logic               boundary_s, capture_s, com_nxt_s;
    logic [7*NDIG-1:0]  dec_s;
    logic [8*NDIG-1:0]  pat_s, seg_nxt_s;
    logic               com_r, ack_r;
    logic [8*NDIG-1:0]  seg_r;

    assign boundary_s = frame_tick && (phase_r == PH_NEG);
    assign capture_s  = boundary_s && load_req;

    // Phase sequencing and watchdog; a tick always beats an expiring count
    always_comb begin
        tmo_cnt_nxt_s   = tmo_cnt_r;
        tick_lost_nxt_s = tick_lost_r;
        phase_nxt_s     = phase_r;
        if (frame_tick) begin
            tmo_cnt_nxt_s   = '0;
            tick_lost_nxt_s = 1'b0;
            phase_nxt_s     = (phase_r == PH_POS) ? PH_NEG : PH_POS;
        end else if (tmo_cnt_r >= TMO_M1_C) begin
            tmo_cnt_nxt_s   = TMO_C;
            tick_lost_nxt_s = 1'b1;
            phase_nxt_s     = PH_POS;
        end else begin
            tmo_cnt_nxt_s   = tmo_cnt_r + CW'(1);
        end
    end

    // Shadow contents for the next cycle: new value only at a requested period boundary
    always_comb begin
        if (capture_s) begin
            sh_hex_nxt_s   = load_hex;
            sh_dp_nxt_s    = load_dp;
            sh_blank_nxt_s = load_blank;
        end else begin
            sh_hex_nxt_s   = sh_hex_r;
            sh_dp_nxt_s    = sh_dp_r;
            sh_blank_nxt_s = sh_blank_r;
        end
    end

    for (genvar g = 0; g < NDIG; g++) begin : g_dec
        seg7_hex_dec u_dec (
            .hex (sh_hex_nxt_s[4*g +: 4]),
            .seg (dec_s[7*g +: 7])
        );
    end

    // Pattern assembly with leading-zero blanking scanned from the top digit down
    always_comb begin
        logic nz_above_v;
        pat_s      = '0;
        nz_above_v = 1'b0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            nz_above_v = nz_above_v | (|sh_hex_nxt_s[4*i +: 4]);
            pat_s[8*i + SEG_DP] = sh_dp_nxt_s[i];
            if ((LZB != 0) && (i != 0) && !nz_above_v) begin
                pat_s[8*i + SEG_A +: 7] = 7'h00;
            end else begin
                pat_s[8*i + SEG_A +: 7] = dec_s[7*i +: 7];
            end
        end
    end

    // Output drive: glass parked at 0 V when ticks are lost, else pattern XOR backplane
    always_comb begin
        com_nxt_s = tick_lost_nxt_s ? 1'b0 : phase_nxt_s[0];
        if (tick_lost_nxt_s) begin
            seg_nxt_s = '0;
        end else if (sh_blank_nxt_s) begin
            seg_nxt_s = {(8*NDIG){com_nxt_s}};
        end else begin
            seg_nxt_s = pat_s ^ {(8*NDIG){com_nxt_s}};
        end
    end

    // Phase, watchdog and shadow state
    always_ff @(posedge osc_clk or negedge nrst) begin
        if (!nrst) begin
            phase_r     <= PH_POS;
            tmo_cnt_r   <= '0;
            tick_lost_r <= 1'b0;
            sh_hex_r    <= '0;
            sh_dp_r     <= '0;
            sh_blank_r  <= 1'b1;
        end else begin
            phase_r     <= phase_nxt_s;
            tmo_cnt_r   <= tmo_cnt_nxt_s;
            tick_lost_r <= tick_lost_nxt_s;
            sh_hex_r    <= sh_hex_nxt_s;
            sh_dp_r     <= sh_dp_nxt_s;
            sh_blank_r  <= sh_blank_nxt_s;
        end
    end

    // Registered pad drivers
    always_ff @(posedge osc_clk or negedge nrst) begin
        if (!nrst) begin
            com_r <= 1'b0;
            seg_r <= '0;
            ack_r <= 1'b0;
        end else begin
            com_r <= com_nxt_s;
            seg_r <= seg_nxt_s;
            ack_r <= capture_s;
        end
    end

    assign lcd_com   = com_r;
    assign lcd_seg   = seg_r;
    assign load_ack  = ack_r;
    assign tick_lost = tick_lost_r;

endmodule
